// File: rtl/fp_adder.sv
// Registered IEEE-754 binary adder with flush-to-zero inputs and round-to-nearest-even.
// One-cycle latency; Sum and status flags are valid after the posedge that samples A/B.
module fp_adder #(
    parameter int EXPONENT_LENGTH = 8,
    parameter int MANTISSA_LENGTH = 23
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [EXPONENT_LENGTH+MANTISSA_LENGTH:0]   A,
    input  logic [EXPONENT_LENGTH+MANTISSA_LENGTH:0]   B,
    output logic [EXPONENT_LENGTH+MANTISSA_LENGTH:0]   Sum,
    output logic                                       Cout,
    output logic                                       overflow,
    output logic                                       underflow,
    output logic                                       exception
);
    localparam int E   = EXPONENT_LENGTH;
    localparam int M   = MANTISSA_LENGTH;
    localparam int W   = E + M + 1;
    localparam int SW  = M + 4;             // hidden + fraction + guard/round/sticky
    localparam int EW  = E + 2;
    localparam int LZW = $clog2(SW + 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << E) - 1);
    localparam logic [W-1:0]         QNAN    = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    logic [W-1:0] sum_q, sum_d;
    logic         cout_q, cout_d, ovf_q, ovf_d, unf_q, unf_d, exc_q, exc_d;

    logic                 sa, sb, sx, sy;
    logic [E-1:0]         ea, eb, ex, ey, diff_e;
    logic [M-1:0]         fa, fb;
    logic [M:0]           mx, my;
    logic                 a_ones, b_ones, a_nan, b_nan, a_zero, b_zero, a_ge_b;
    logic [E-1:0]         shamt;
    logic [2*SW-1:0]      y_wide;
    logic [SW-1:0]        x_al, y_al, diff_v, norm_v;
    logic [SW:0]          add_v;
    logic [LZW-1:0]       lzc;
    logic                 lz_found, round_up;
    logic [M+1:0]         rnd_v;
    logic [M-1:0]         frac_f;
    logic signed [EW-1:0] exp_n, exp_f;

    always_comb begin
        sum_d    = '0;
        cout_d   = 1'b0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        exc_d    = 1'b0;
        lzc      = '0;
        lz_found = 1'b0;
        norm_v   = '0;
        exp_n    = '0;

        sa = A[W-1];  ea = A[W-2:M];  fa = A[M-1:0];
        sb = B[W-1];  eb = B[W-2:M];  fb = B[M-1:0];
        a_ones = &ea;
        b_ones = &eb;
        a_nan  = a_ones & (|fa);
        b_nan  = b_ones & (|fb);
        a_zero = ~|ea;
        b_zero = ~|eb;
        a_ge_b = {ea, fa} >= {eb, fb};

        sx = a_ge_b ? sa : sb;
        sy = a_ge_b ? sb : sa;
        ex = a_ge_b ? ea : eb;
        ey = a_ge_b ? eb : ea;
        mx = a_ge_b ? {1'b1, fa} : {1'b1, fb};
        my = a_ge_b ? {1'b1, fb} : {1'b1, fa};
        diff_e = ex - ey;

        // Shifts past the sticky position all collapse to the same sticky-only result.
        shamt  = ({2'b00, diff_e} >= EW'(M + 3)) ? E'(M + 3) : diff_e;
        y_wide = {my, 3'b000, {SW{1'b0}}} >> shamt;
        y_al   = y_wide[2*SW-1:SW] | {{(SW-1){1'b0}}, |y_wide[SW-1:0]};
        x_al   = {mx, 3'b000};

        add_v  = {1'b0, x_al} + {1'b0, y_al};
        diff_v = x_al - y_al;

        for (int i = SW - 1; i >= 0; i--) begin
            if (!lz_found) begin
                if (diff_v[i]) lz_found = 1'b1;
                else           lzc = lzc + LZW'(1);
            end
        end

        if (sx == sy) begin
            if (add_v[SW]) begin
                norm_v = {add_v[SW:2], add_v[1] | add_v[0]};
                exp_n  = $signed({2'b00, ex}) + EW'(1);
            end else begin
                norm_v = add_v[SW-1:0];
                exp_n  = $signed({2'b00, ex});
            end
        end else begin
            norm_v = diff_v << lzc;
            exp_n  = $signed({2'b00, ex}) - $signed({{(EW-LZW){1'b0}}, lzc});
        end

        round_up = norm_v[2] & (norm_v[1] | norm_v[0] | norm_v[3]);
        rnd_v    = {1'b0, norm_v[SW-1:3]} + (M+2)'(round_up);
        if (rnd_v[M+1]) begin
            frac_f = rnd_v[M:1];
            exp_f  = exp_n + EW'(1);
        end else begin
            frac_f = rnd_v[M-1:0];
            exp_f  = exp_n;
        end

        if (a_ones || b_ones) begin
            exc_d = 1'b1;
            if (a_nan || b_nan || (a_ones && b_ones && (sa != sb))) sum_d = QNAN;
            else if (a_ones)                                        sum_d = A;
            else                                                    sum_d = B;
        end else if (a_zero && b_zero) begin
            sum_d = {sa & sb, {(W-1){1'b0}}};
        end else if (a_zero) begin
            sum_d = B;
        end else if (b_zero) begin
            sum_d = A;
        end else if ((sx != sy) && (diff_v == '0)) begin
            sum_d = '0;
        end else begin
            cout_d = (sx == sy) & add_v[SW];
            if (exp_f >= EXP_MAX) begin
                ovf_d = 1'b1;
                sum_d = {sx, {E{1'b1}}, {M{1'b0}}};
            end else if (exp_f <= 0) begin
                unf_d = 1'b1;
                sum_d = {sx, {(W-1){1'b0}}};
            end else begin
                sum_d = {sx, exp_f[E-1:0], frac_f};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            exc_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            exc_q  <= exc_d;
        end
    end

    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign exception = exc_q;
endmodule

// File: tb/tb_fp_adder.sv
// Directed-vector bench for fp_adder (single precision); expected values computed by hand.
module tb_fp_adder;
    logic        clk;
    logic        rst;
    logic [31:0] A, B, Sum;
    logic        Cout, overflow, underflow, exception;
    int          checks = 0;
    int          errors = 0;

    fp_adder #(.EXPONENT_LENGTH(8), .MANTISSA_LENGTH(23)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .Sum(Sum),
        .Cout(Cout), .overflow(overflow), .underflow(underflow), .exception(exception)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags ordering: {Cout, overflow, underflow, exception}
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_sum, input logic [3:0] exp_flags);
        A = a;
        B = b;
        @(posedge clk);
        #1;
        checks++;
        assert (Sum === exp_sum) else begin
            errors++;
            $error("FAIL %s sum: got %h expected %h", tag, Sum, exp_sum);
        end
        checks++;
        assert ({Cout, overflow, underflow, exception} === exp_flags) else begin
            errors++;
            $error("FAIL %s flags: got %b expected %b", tag, {Cout, overflow, underflow, exception}, exp_flags);
        end
    endtask

    initial begin
        rst = 1'b1;
        A   = 32'h7f7fffff;
        B   = 32'h7f7fffff;
        @(posedge clk);
        #1;
        step("reset_hold", 32'h7f800000, 32'hff800000, 32'h00000000, 4'b0000);
        rst = 1'b0;

        step("add_carry",   32'h40480000, 32'h40480000, 32'h40c80000, 4'b1000);
        step("add_nocarry", 32'h40200000, 32'h40a40000, 32'h40f40000, 4'b0000);
        step("add_small",   32'h3d800000, 32'h3e000000, 32'h3e400000, 4'b0000);
        step("sub_mixed",   32'h40a80000, 32'hc0440000, 32'h400c0000, 4'b0000);
        step("sub_swapped", 32'hc0440000, 32'h40a80000, 32'h400c0000, 4'b0000);
        step("neg_add",     32'hc0a80000, 32'hc0480000, 32'hc1060000, 4'b1000);
        step("overflow",    32'h7f7fffff, 32'h7f7fffff, 32'h7f800000, 4'b1100);
        step("inf_minus",   32'h7f800000, 32'hff800000, 32'h7fc00000, 4'b0001);
        step("nan_in",      32'h7fc00001, 32'h3f800000, 32'h7fc00000, 4'b0001);
        step("inf_plus1",   32'h3f800000, 32'hff800000, 32'hff800000, 4'b0001);
        step("cancel",      32'h3f800000, 32'hbf800000, 32'h00000000, 4'b0000);
        step("zero_pass",   32'h00000000, 32'hc0a80000, 32'hc0a80000, 4'b0000);
        step("subnorm_ftz", 32'h40200000, 32'h00000001, 32'h40200000, 4'b0000);
        step("negzero_sum", 32'h80000000, 32'h80000000, 32'h80000000, 4'b0000);
        step("mixzero_sum", 32'h80000000, 32'h00000000, 32'h00000000, 4'b0000);
        step("underflow",   32'h00c00000, 32'h80800000, 32'h00000000, 4'b0010);
        step("tie_even",    32'h3f800000, 32'h33800000, 32'h3f800000, 4'b0000);
        step("tie_odd_up",  32'h3f800001, 32'h33800000, 32'h3f800002, 4'b0000);
        step("round_carry", 32'h3fffffff, 32'h33800000, 32'h40000000, 4'b0000);
        step("far_sticky",  32'h3f800000, 32'h00800000, 32'h3f800000, 4'b0000);
        step("sub_renorm",  32'h3f800000, 32'hbf7fffff, 32'h33800000, 4'b0000);

        rst = 1'b1;
        step("reset_mid",   32'h40480000, 32'h40480000, 32'h00000000, 4'b0000);
        rst = 1'b0;
        step("after_reset", 32'h40480000, 32'h40480000, 32'h40c80000, 4'b1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
